// File: rtl/agc_scale_pkg.sv
// Shared helpers for the multi-channel AGC saturate/scale stage.
package agc_scale_pkg;

  localparam int LSB_MIN = 1;

  function automatic int field_w(input int out_bits);
    return out_bits - 1;
  endfunction

  function automatic int lsb_max(input int in_bits, input int out_bits);
    return in_bits - out_bits;
  endfunction

  // Offset-binary saturation: negative overflow pins to all zeros, positive to all ones.
  function automatic logic [7:0] sat_code(input logic sign);
    return sign ? 8'h00 : 8'hFF;
  endfunction

  typedef struct packed {
    logic valid;
    logic missed;
  } cnt_hs_t;

endpackage

// File: rtl/agc_scale_multi_if.sv
// Windowed GT/LT count handshake towards the AGC control loop.
interface agc_scale_multi_if #(
  parameter int NCHAN    = 8,
  parameter int CNT_BITS = 24
);
  logic [NCHAN*CNT_BITS-1:0] gt_count_o;
  logic [NCHAN*CNT_BITS-1:0] lt_count_o;
  logic                      count_valid_o;
  logic                      count_ready_i;
  logic                      count_missed_o;

  modport master (
    output gt_count_o, lt_count_o, count_valid_o, count_missed_o,
    input  count_ready_i
  );

  modport slave (
    input  gt_count_o, lt_count_o, count_valid_o, count_missed_o,
    output count_ready_i
  );
endinterface

// File: rtl/agc_scale_chan.sv
// One channel: 2-stage scale/round/saturate datapath plus GT/LT window counters.
module agc_scale_chan
  import agc_scale_pkg::*;
#(
  parameter int IN_BITS  = 48,
  parameter int OUT_BITS = 5,
  parameter int LSB_BITS = 6,
  parameter int CNT_BITS = 24
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [IN_BITS-1:0]  dat,
  input  logic [LSB_BITS-1:0] lsb,
  input  logic [OUT_BITS-2:0] thresh,
  input  logic                win_last,
  output logic [OUT_BITS-1:0] code,
  output logic [OUT_BITS-2:0] abs_val,
  output logic                gt,
  output logic                lt,
  output logic [CNT_BITS-1:0] gt_sum,
  output logic [CNT_BITS-1:0] lt_sum
);
  localparam int FW = field_w(OUT_BITS);

  logic [LSB_BITS-1:0]       lsb_m1, sh;
  logic signed [IN_BITS-1:0] top_bits;
  logic [OUT_BITS-1:0]       s1_fld;
  logic                      s1_oob, s1_rnd, s1_sign;
  logic [OUT_BITS-1:0]       sat_n, code_n;
  logic [FW-1:0]             abs_n;
  logic                      gt_n, lt_n;
  logic [CNT_BITS-1:0]       cnt_gt, cnt_lt;

  // Everything from bit L+OUT_BITS-1 upward must be pure sign extension.
  assign lsb_m1   = lsb - 1'b1;
  assign sh       = lsb + LSB_BITS'(OUT_BITS - 1);
  assign top_bits = $signed(dat) >>> sh;

  // Out-of-bounds is stored (not in-bounds) so a cleared stage equals a zero sample.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_fld  <= '0;
      s1_oob  <= 1'b0;
      s1_rnd  <= 1'b0;
      s1_sign <= 1'b0;
    end else begin
      s1_fld  <= dat[lsb +: OUT_BITS];
      s1_oob  <= !((&top_bits) || (~|top_bits));
      s1_rnd  <= dat[lsb_m1];
      s1_sign <= dat[IN_BITS-1];
    end
  end

  assign sat_n = OUT_BITS'(sat_code(s1_sign));

  always_comb begin
    code_n = sat_n;
    abs_n  = '1;
    if (!s1_oob) begin
      code_n = {~s1_sign, s1_fld[OUT_BITS-2:1], s1_fld[0] | s1_rnd};
      abs_n  = code_n[FW-1:0] ^ {FW{s1_sign}};
    end
    gt_n = !s1_sign && (abs_n >= thresh);
    lt_n =  s1_sign && (abs_n >= thresh);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      code    <= '0;
      abs_val <= '0;
      gt      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      code    <= code_n;
      abs_val <= abs_n;
      gt      <= gt_n;
      lt      <= lt_n;
    end
  end

  assign gt_sum = (&cnt_gt) ? cnt_gt : cnt_gt + CNT_BITS'(gt);
  assign lt_sum = (&cnt_lt) ? cnt_lt : cnt_lt + CNT_BITS'(lt);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_gt <= '0;
      cnt_lt <= '0;
    end else begin
      cnt_gt <= win_last ? '0 : gt_sum;
      cnt_lt <= win_last ? '0 : lt_sum;
    end
  end

endmodule

// File: rtl/agc_scale_multi.sv
// Multi-channel AGC saturate/scale stage: shadowed config, window timer and
// count handshake around NCHAN channel datapaths.
module agc_scale_multi
  import agc_scale_pkg::*;
#(
  parameter int NCHAN    = 8,
  parameter int IN_BITS  = 48,
  parameter int OUT_BITS = 5,
  parameter int LSB_BITS = 6,
  parameter int CNT_BITS = 24
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic [NCHAN*IN_BITS-1:0]    dat_i,
  input  logic [LSB_BITS-1:0]         lsb_i,
  input  logic [OUT_BITS-2:0]         thresh_i,
  input  logic [CNT_BITS-1:0]         period_i,
  output logic [NCHAN*OUT_BITS-1:0]   dat_o,
  output logic [NCHAN*(OUT_BITS-1)-1:0] abs_o,
  output logic [NCHAN-1:0]            gt_o,
  output logic [NCHAN-1:0]            lt_o,
  agc_scale_multi_if.master           cnt
);
  localparam int FW   = field_w(OUT_BITS);
  localparam int LMAX = lsb_max(IN_BITS, OUT_BITS);

  logic                      started_q, last_q, load;
  logic [CNT_BITS-1:0]       tmr_q, tmr_e;
  logic [LSB_BITS-1:0]       lsb_q, lsb_c, lsb_e;
  logic [FW-1:0]             thr_q, thr_e;
  logic                      win_last;
  logic [NCHAN*CNT_BITS-1:0] gt_sum, lt_sum, gt_cnt_q, lt_cnt_q;
  cnt_hs_t                   hs_q;

  always_comb begin
    lsb_c = lsb_i;
    if (lsb_i < LSB_BITS'(LSB_MIN))
      lsb_c = LSB_BITS'(LSB_MIN);
    else if (lsb_i > LSB_BITS'(LMAX))
      lsb_c = LSB_BITS'(LMAX);
  end

  // A window's first cycle takes config straight from the inputs; later cycles use the shadows.
  assign load     = !started_q || last_q;
  assign lsb_e    = load ? lsb_c    : lsb_q;
  assign thr_e    = load ? thresh_i : thr_q;
  assign tmr_e    = load ? period_i : tmr_q;
  assign win_last = (tmr_e == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      started_q <= 1'b0;
      last_q    <= 1'b0;
      tmr_q     <= '0;
      lsb_q     <= '0;
      thr_q     <= '0;
      gt_cnt_q  <= '0;
      lt_cnt_q  <= '0;
      hs_q      <= '0;
    end else begin
      started_q <= 1'b1;
      last_q    <= win_last;
      tmr_q     <= tmr_e - 1'b1;
      lsb_q     <= lsb_e;
      thr_q     <= thr_e;
      if (win_last) begin
        if (!hs_q.valid || cnt.count_ready_i) begin
          gt_cnt_q    <= gt_sum;
          lt_cnt_q    <= lt_sum;
          hs_q.valid  <= 1'b1;
          hs_q.missed <= 1'b0;
        end else begin
          hs_q.missed <= 1'b1;
        end
      end else if (hs_q.valid && cnt.count_ready_i) begin
        hs_q.valid <= 1'b0;
      end
    end
  end

  assign cnt.gt_count_o     = gt_cnt_q;
  assign cnt.lt_count_o     = lt_cnt_q;
  assign cnt.count_valid_o  = hs_q.valid;
  assign cnt.count_missed_o = hs_q.missed;

  for (genvar c = 0; c < NCHAN; c++) begin : g_chan
    agc_scale_chan #(
      .IN_BITS (IN_BITS),
      .OUT_BITS(OUT_BITS),
      .LSB_BITS(LSB_BITS),
      .CNT_BITS(CNT_BITS)
    ) u_chan (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .dat     (dat_i[c*IN_BITS +: IN_BITS]),
      .lsb     (lsb_e),
      .thresh  (thr_e),
      .win_last(win_last),
      .code    (dat_o[c*OUT_BITS +: OUT_BITS]),
      .abs_val (abs_o[c*FW +: FW]),
      .gt      (gt_o[c]),
      .lt      (lt_o[c]),
      .gt_sum  (gt_sum[c*CNT_BITS +: CNT_BITS]),
      .lt_sum  (lt_sum[c*CNT_BITS +: CNT_BITS])
    );
  end

endmodule

// File: tb/tb_agc_scale_multi.sv
// Self-checking bench for agc_scale_multi against an arithmetic reference model.
module tb_agc_scale_multi;
  localparam int N  = 8;
  localparam int IB = 48;
  localparam int OB = 5;
  localparam int LB = 6;
  localparam int CB = 24;
  localparam int FW = OB - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N*IB-1:0]   dat;
  logic [LB-1:0]     lsb;
  logic [FW-1:0]     thr;
  logic [CB-1:0]     period;
  logic [N*OB-1:0]   dat_o;
  logic [N*FW-1:0]   abs_o;
  logic [N-1:0]      gt_o, lt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  agc_scale_multi_if #(.NCHAN(N), .CNT_BITS(CB)) cif();

  agc_scale_multi #(
    .NCHAN(N), .IN_BITS(IB), .OUT_BITS(OB), .LSB_BITS(LB), .CNT_BITS(CB)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .dat_i   (dat),
    .lsb_i   (lsb),
    .thresh_i(thr),
    .period_i(period),
    .dat_o   (dat_o),
    .abs_o   (abs_o),
    .gt_o    (gt_o),
    .lt_o    (lt_o),
    .cnt     (cif)
  );

  // ---------------- reference model ----------------
  int     m_code[N], m_abs[N], s1_code[N], s1_abs[N];
  bit     m_gt[N], m_lt[N], s1_neg[N];
  longint m_cg[N], m_cl[N], m_gtc[N], m_ltc[N];
  bit     m_valid, m_missed;
  int     win_pos, win_len, sh_lsb, sh_thr, m_edge;

  function automatic int clamp_lsb(int l);
    if (l < 1) return 1;
    if (l > IB - OB) return IB - OB;
    return l;
  endfunction

  function automatic bit ref_oob(longint v, int l);
    longint lim;
    lim = longint'(1) << (l + OB - 1);
    return (v >= lim) || (v < -lim);
  endfunction

  function automatic int ref_code(longint v, int l);
    longint q;
    int     r;
    if (ref_oob(v, l)) return (v < 0) ? 0 : (1 << OB) - 1;
    q = v >>> l;
    r = int'((v >>> (l - 1)) & 1);
    return int'((q + (1 << (OB - 1))) & ((1 << OB) - 1)) | r;
  endfunction

  function automatic int ref_abs(longint v, int l);
    int low;
    if (ref_oob(v, l)) return (1 << FW) - 1;
    low = ref_code(v, l) & ((1 << FW) - 1);
    return (v < 0) ? ((1 << FW) - 1 - low) : low;
  endfunction

  function automatic longint chan_val(int c);
    logic [IB-1:0] w;
    w = dat[c*IB +: IB];
    return longint'($signed(w));
  endfunction

  task automatic mdl_edge();
    bit     last;
    longint sat, g, l;
    longint v;
    sat = (longint'(1) << CB) - 1;
    if (!rst_n) begin
      for (int c = 0; c < N; c++) begin
        m_code[c] = 0; m_abs[c] = 0; m_gt[c] = 0; m_lt[c] = 0;
        s1_code[c] = 1 << (OB - 1); s1_abs[c] = 0; s1_neg[c] = 0;
        m_cg[c] = 0; m_cl[c] = 0; m_gtc[c] = 0; m_ltc[c] = 0;
      end
      m_valid = 0; m_missed = 0; win_pos = 0; win_len = 1;
      sh_lsb = 0; sh_thr = 0; m_edge = 0;
      return;
    end
    if (win_pos == 0) begin
      sh_lsb  = clamp_lsb(int'(lsb));
      sh_thr  = int'(thr);
      win_len = int'(period) + 1;
    end
    last = (win_pos == win_len - 1);
    for (int c = 0; c < N; c++) begin
      g = m_cg[c] + longint'(m_gt[c]); if (g > sat) g = sat;
      l = m_cl[c] + longint'(m_lt[c]); if (l > sat) l = sat;
      m_cg[c] = last ? 0 : g;
      m_cl[c] = last ? 0 : l;
      if (last && (!m_valid || cif.count_ready_i)) begin
        m_gtc[c] = g; m_ltc[c] = l;
      end
    end
    if (last) begin
      if (!m_valid || cif.count_ready_i) begin m_valid = 1; m_missed = 0; end
      else m_missed = 1;
    end else if (m_valid && cif.count_ready_i) begin
      m_valid = 0;
    end
    for (int c = 0; c < N; c++) begin
      m_code[c] = s1_code[c];
      m_abs[c]  = s1_abs[c];
      m_gt[c]   = !s1_neg[c] && (s1_abs[c] >= sh_thr);
      m_lt[c]   =  s1_neg[c] && (s1_abs[c] >= sh_thr);
      v = chan_val(c);
      s1_code[c] = ref_code(v, sh_lsb);
      s1_abs[c]  = ref_abs(v, sh_lsb);
      s1_neg[c]  = (v < 0);
    end
    win_pos = last ? 0 : win_pos + 1;
    m_edge++;
  endtask

  task automatic step();
    @(posedge clk);
    mdl_edge();
    #1;
  endtask

  function automatic logic [IB-1:0] rnd_val();
    longint m;
    int     k;
    k = $urandom_range(1, 24);
    m = $signed({$urandom, $urandom});
    m = m >>> (64 - k);
    return m[IB-1:0];
  endfunction

  task automatic set_ch(int c, longint v);
    dat[c*IB +: IB] = v[IB-1:0];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    for (int c = 0; c < N; c++) dat[c*IB +: IB] = rnd_val();
    cif.count_ready_i = 1; lsb = 4; thr = 8; period = 3;
    repeat (3) step();
    n_vec++;
    if (dat_o !== '0 || abs_o !== '0 || gt_o !== '0 || lt_o !== '0) begin
      n_err++;
      $display("FAIL reset_dp: got dat=%h abs=%h gt=%b lt=%b, expected all 0", dat_o, abs_o, gt_o, lt_o);
    end
    n_vec++;
    if (cif.count_valid_o !== 1'b0 || cif.count_missed_o !== 1'b0 ||
        cif.gt_count_o !== '0 || cif.lt_count_o !== '0) begin
      n_err++;
      $display("FAIL reset_cnt: got valid=%b missed=%b, expected 0 0", cif.count_valid_o, cif.count_missed_o);
    end
  endtask

  task automatic test_directed();
    int exp_c[4] = '{25, 31, 15, 0};
    int exp_a[4] = '{9, 15, 0, 15};
    bit exp_g[4] = '{1, 1, 0, 0};
    bit exp_l[4] = '{0, 0, 0, 1};
    rst_n = 0; dat = '0; step();
    lsb = 4; thr = 8; period = 99; cif.count_ready_i = 1; rst_n = 1;
    set_ch(0, 64'h90); set_ch(1, 64'h200); set_ch(2, -1); set_ch(3, -512);
    step(); step();
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (dat_o[c*OB +: OB] !== OB'(exp_c[c]) || abs_o[c*FW +: FW] !== FW'(exp_a[c]) ||
          gt_o[c] !== exp_g[c] || lt_o[c] !== exp_l[c]) begin
        n_err++;
        $display("FAIL directed ch%0d: got code=%b abs=%0d gt=%b lt=%b, expected code=%0d abs=%0d gt=%b lt=%b",
                 c, dat_o[c*OB +: OB], abs_o[c*FW +: FW], gt_o[c], lt_o[c], exp_c[c], exp_a[c], exp_g[c], exp_l[c]);
      end
    end
  endtask

  task automatic test_lsb_shadow();
    int first18;
    bit err;
    first18 = -1;
    err = 0;
    set_ch(0, 64'h90);
    for (int i = 0; i < 140; i++) begin
      if (i == 5) lsb = 6;
      for (int c = 1; c < N; c++) dat[c*IB +: IB] = rnd_val();
      step();
      if (first18 < 0 && dat_o[OB-1:0] == OB'(18)) first18 = m_edge;
      for (int c = 0; c < N; c++)
        if (dat_o[c*OB +: OB] !== OB'(m_code[c]) || abs_o[c*FW +: FW] !== FW'(m_abs[c]) ||
            gt_o[c] !== m_gt[c] || lt_o[c] !== m_lt[c]) begin
          if (!err) $display("FAIL lsb_dp ch%0d edge %0d: got code=%0d abs=%0d, expected code=%0d abs=%0d",
                             c, m_edge, dat_o[c*OB +: OB], abs_o[c*FW +: FW], m_code[c], m_abs[c]);
          err = 1;
        end
    end
    n_vec++;
    if (err) n_err++;
    n_vec++;
    if (first18 != 102) begin
      n_err++;
      $display("FAIL lsb_switch: new code seen after edge count %0d, expected 102", first18);
    end
  endtask

  task automatic test_counts();
    int  nlatch;
    bit  err;
    nlatch = 0; err = 0;
    rst_n = 0; step();
    lsb = 4; thr = 8; period = 9; cif.count_ready_i = 1; rst_n = 1;
    set_ch(0, 64'h90);
    for (int i = 0; i < 45; i++) begin
      for (int c = 1; c < N; c++) dat[c*IB +: IB] = rnd_val();
      step();
      if (cif.count_valid_o === 1'b1) begin
        n_vec++;
        if (cif.gt_count_o[CB-1:0] !== CB'(nlatch == 0 ? 8 : 10) || cif.count_missed_o !== 1'b0 ||
            m_edge % 10 != 0) begin
          n_err++;
          $display("FAIL window_count #%0d: got gt=%0d missed=%b at edge %0d, expected gt=%0d missed=0 at multiple of 10",
                   nlatch, cif.gt_count_o[CB-1:0], cif.count_missed_o, m_edge, nlatch == 0 ? 8 : 10);
        end
        nlatch++;
      end
      if (cif.count_valid_o !== m_valid || cif.count_missed_o !== m_missed) err = 1;
      for (int c = 0; c < N; c++)
        if (cif.gt_count_o[c*CB +: CB] !== CB'(m_gtc[c]) || cif.lt_count_o[c*CB +: CB] !== CB'(m_ltc[c]))
          err = 1;
    end
    n_vec++;
    if (err || nlatch != 4) begin
      n_err++;
      $display("FAIL counts_model: latches seen %0d, expected 4; model disagreement=%b", nlatch, err);
    end
  endtask

  task automatic test_missed();
    bit err;
    err = 0;
    cif.count_ready_i = 0;
    for (int i = 0; i < 30; i++) begin
      for (int c = 1; c < N; c++) dat[c*IB +: IB] = rnd_val();
      step();
      if (cif.count_valid_o !== m_valid || cif.count_missed_o !== m_missed ||
          cif.gt_count_o !== {m_gtc[7][CB-1:0], m_gtc[6][CB-1:0], m_gtc[5][CB-1:0], m_gtc[4][CB-1:0],
                              m_gtc[3][CB-1:0], m_gtc[2][CB-1:0], m_gtc[1][CB-1:0], m_gtc[0][CB-1:0]})
        err = 1;
    end
    n_vec++;
    if (cif.count_missed_o !== 1'b1 || cif.count_valid_o !== 1'b1 || cif.gt_count_o[CB-1:0] !== CB'(10)) begin
      n_err++;
      $display("FAIL missed_hold: got missed=%b valid=%b gt=%0d, expected 1 1 10",
               cif.count_missed_o, cif.count_valid_o, cif.gt_count_o[CB-1:0]);
    end
    cif.count_ready_i = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cif.count_valid_o !== m_valid || cif.count_missed_o !== m_missed) err = 1;
    end
    cif.count_ready_i = 0;
    n_vec++;
    if (cif.count_missed_o !== 1'b0 || err) begin
      n_err++;
      $display("FAIL missed_clear: got missed=%b, expected 0; model disagreement=%b", cif.count_missed_o, err);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    repeat (4) step();
    rst_n = 0;
    step();
    n_vec++;
    if (dat_o !== '0 || abs_o !== '0 || gt_o !== '0 || lt_o !== '0 || cif.count_valid_o !== 1'b0 ||
        cif.count_missed_o !== 1'b0 || cif.gt_count_o !== '0 || cif.lt_count_o !== '0) begin
      n_err++;
      $display("FAIL mid_reset: got valid=%b missed=%b dat=%h, expected all 0", cif.count_valid_o, cif.count_missed_o, dat_o);
    end
    rst_n = 1;
    n = 0;
    while (cif.count_valid_o !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    n_vec++;
    if (n != 10 || cif.gt_count_o[CB-1:0] !== CB'(8)) begin
      n_err++;
      $display("FAIL post_reset_window: got length %0d gt=%0d, expected 10 8", n, cif.gt_count_o[CB-1:0]);
    end
  endtask

  task automatic test_random();
    bit err_dp, err_cnt;
    for (int i = 0; i < 400; i++) begin
      if (i % 23 == 0) begin
        lsb    = ($urandom_range(0, 3) == 0) ? LB'($urandom_range(0, 63)) : LB'($urandom_range(1, 8));
        thr    = FW'($urandom_range(0, 15));
        period = CB'($urandom_range(0, 7));
      end
      cif.count_ready_i = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < N; c++) dat[c*IB +: IB] = rnd_val();
      rst_n = (i == 200) ? 1'b0 : 1'b1;
      step();
      err_dp = 0; err_cnt = 0;
      for (int c = 0; c < N; c++) begin
        if (dat_o[c*OB +: OB] !== OB'(m_code[c]) || abs_o[c*FW +: FW] !== FW'(m_abs[c]) ||
            gt_o[c] !== m_gt[c] || lt_o[c] !== m_lt[c]) err_dp = 1;
        if (cif.gt_count_o[c*CB +: CB] !== CB'(m_gtc[c]) || cif.lt_count_o[c*CB +: CB] !== CB'(m_ltc[c]))
          err_cnt = 1;
      end
      if (cif.count_valid_o !== m_valid || cif.count_missed_o !== m_missed) err_cnt = 1;
      n_vec++;
      if (err_dp || err_cnt) begin
        n_err++;
        $display("FAIL random cycle %0d: datapath=%b counts=%b; got ch0 code=%0d valid=%b, expected code=%0d valid=%b",
                 i, err_dp, err_cnt, dat_o[OB-1:0], cif.count_valid_o, m_code[0], m_valid);
      end
    end
  endtask

  initial begin
    rst_n = 0; dat = '0; lsb = 4; thr = 8; period = 0; cif.count_ready_i = 0;
    test_reset();
    test_directed();
    test_lsb_shadow();
    test_counts();
    test_missed();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
